// File: rtl/ram_ctrl_if.sv
// Command/response handshake bundle between a client and ram_ctrl.
interface ram_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ram_ctrl.sv
// Sole master of a single-port RAM: serialises read/write commands, holds read
// responses until consumed, and sweeps the whole memory with CLEAR_VALUE on request.
module ram_ctrl #(
    parameter int unsigned          DATA_WIDTH  = 16,
    parameter int unsigned          ADDR_WIDTH  = 10,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_ctrl_if.slave             bus,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  ram_request,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

    typedef enum logic [2:0] {StIdle, StIssueWr, StIssueRd, StCapture, StClear} state_e;

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cmd_ready;

    // A pending response blocks new commands but not a clear request.
    assign cmd_ready = !rst && (state_q == StIdle) && !rsp_valid_q && !clear_start;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (clear_start) begin
                    state_d = StClear;
                    addr_d  = '0;
                    req_d   = 1'b1;
                    wdata_d = CLEAR_VALUE;
                    busy_d  = 1'b1;
                end else if (bus.cmd_valid && cmd_ready) begin
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    req_d   = bus.cmd_we;
                    state_d = bus.cmd_we ? StIssueWr : StIssueRd;
                end
            end
            StIssueWr: begin
                req_d   = 1'b0;
                state_d = StIdle;
            end
            StIssueRd: state_d = StCapture;
            StCapture: begin
                rsp_data_d  = ram_read_data;
                rsp_valid_d = 1'b1;
                state_d     = StIdle;
            end
            StClear: begin
                if (addr_q == LastAddr) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign clear_busy     = busy_q;
    assign clear_done     = done_q;
    assign ram_request    = req_q;
    assign ram_addr       = addr_q;
    assign ram_write_data = wdata_q;
endmodule
